// File: rtl/pipe_step_ctrl.sv
// Run / single-step / halt controller that grants one pipeline clock-enable pulse per slow_clk tick.
// Optional macro STEP_DEBOUNCE_EN adds a step_btn debouncer of DEBOUNCE_CYCLES stable cycles.
module pipe_step_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 32
) (
  input  logic             clk_signal,
  input  logic             reset,
  input  logic             slow_clk,
  input  logic             run_sw,
  input  logic             step_btn,
  input  logic             halt_req,
  input  logic             clear_halt,
  output logic             cpu_ce,
  output logic [CNT_W-1:0] cycle_count,
  output logic [1:0]       state,
  output logic             halted
);

  typedef enum logic [1:0] {
    ST_PAUSE  = 2'b00,
    ST_RUN    = 2'b01,
    ST_STEP   = 2'b10,
    ST_HALTED = 2'b11
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_slow_s1, r_slow_s2, r_slow_d, r_armed;
  logic [1:0]       r_fill;
  logic             r_run_s1, r_run_s2;
  logic             r_step_s1, r_step_s2, r_step_d;
  logic             w_step_db, w_tick, w_press, w_ce_nxt;
  logic             r_cpu_ce, r_halted;
  logic [CNT_W-1:0] r_count;

  // Armed only once a low slow_clk sample is seen after the sync chain refills, so a
  // slow_clk already high at reset release never counts as a tick.
  always_ff @(posedge clk_signal or posedge reset) begin
    if (reset) begin
      r_slow_s1 <= 1'b0;
      r_slow_s2 <= 1'b0;
      r_slow_d  <= 1'b0;
      r_fill    <= 2'b00;
      r_armed   <= 1'b0;
      r_run_s1  <= 1'b0;
      r_run_s2  <= 1'b0;
      r_step_s1 <= 1'b0;
      r_step_s2 <= 1'b0;
      r_step_d  <= 1'b0;
    end else begin
      r_slow_s1 <= slow_clk;
      r_slow_s2 <= r_slow_s1;
      r_slow_d  <= r_slow_s2;
      r_fill    <= {r_fill[0], 1'b1};
      r_armed   <= r_armed | (r_fill[1] & ~r_slow_s2);
      r_run_s1  <= run_sw;
      r_run_s2  <= r_run_s1;
      r_step_s1 <= step_btn;
      r_step_s2 <= r_step_s1;
      r_step_d  <= w_step_db;
    end
  end

`ifdef STEP_DEBOUNCE_EN
  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [DB_W-1:0] r_db_cnt;
  logic            r_step_db;

  // Debounced level follows the synchronized button after a full run of matching samples.
  always_ff @(posedge clk_signal or posedge reset) begin
    if (reset) begin
      r_db_cnt  <= {DB_W{1'b0}};
      r_step_db <= 1'b0;
    end else if (r_step_s2 == r_step_db) begin
      r_db_cnt  <= {DB_W{1'b0}};
    end else if (r_db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
      r_db_cnt  <= {DB_W{1'b0}};
      r_step_db <= r_step_s2;
    end else begin
      r_db_cnt  <= r_db_cnt + DB_W'(1);
    end
  end

  assign w_step_db = r_step_db;
`else
  localparam int debounce_unused = DEBOUNCE_CYCLES;
  assign w_step_db = r_step_s2;
`endif

  assign w_tick  = r_armed & r_slow_s2 & ~r_slow_d;
  assign w_press = w_step_db & ~r_step_d;

  // Next-state and pulse-grant decision.
  always_comb begin
    w_state_nxt = r_state;
    w_ce_nxt    = 1'b0;
    case (r_state)
      ST_PAUSE: begin
        if (r_run_s2) begin
          w_state_nxt = ST_RUN;
        end else if (w_press) begin
          w_state_nxt = ST_STEP;
        end else begin
          w_state_nxt = ST_PAUSE;
        end
      end
      ST_RUN: begin
        if (halt_req) begin
          w_state_nxt = ST_HALTED;
        end else if (!r_run_s2) begin
          w_state_nxt = ST_PAUSE;
        end else begin
          w_ce_nxt = w_tick;
        end
      end
      ST_STEP: begin
        if (halt_req) begin
          w_state_nxt = ST_HALTED;
        end else if (w_tick) begin
          w_ce_nxt    = 1'b1;
          w_state_nxt = ST_PAUSE;
        end else begin
          w_state_nxt = ST_STEP;
        end
      end
      ST_HALTED: begin
        if (clear_halt && !halt_req) begin
          w_state_nxt = ST_PAUSE;
        end else begin
          w_state_nxt = ST_HALTED;
        end
      end
      default: begin
        w_state_nxt = ST_PAUSE;
      end
    endcase
  end

  // State, registered outputs and the pulse counter.
  always_ff @(posedge clk_signal or posedge reset) begin
    if (reset) begin
      r_state  <= ST_PAUSE;
      r_cpu_ce <= 1'b0;
      r_halted <= 1'b0;
      r_count  <= {CNT_W{1'b0}};
    end else begin
      r_state  <= w_state_nxt;
      r_cpu_ce <= w_ce_nxt;
      r_halted <= (w_state_nxt == ST_HALTED);
      if (w_ce_nxt) begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  assign cpu_ce      = r_cpu_ce;
  assign cycle_count = r_count;
  assign state       = r_state;
  assign halted      = r_halted;

endmodule
